// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO subsystem: window bases,
// MMIO register offsets and STATUS bit positions.
package dmem_mmio_pkg;

    localparam logic [15:0] RAM_BASE_HI_DEF  = 16'h1001;
    localparam logic [15:0] MMIO_BASE_HI_DEF = 16'hFFFF;

    localparam logic [3:0] OFF_GPIO = 4'h0;
    localparam logic [3:0] OFF_CNT  = 4'h4;
    localparam logic [3:0] OFF_CMP  = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    localparam int ST_MATCH = 0;
    localparam int ST_FAULT = 1;

endpackage

// File: rtl/dmem_ram.sv
// Word RAM: synchronous write, asynchronous read, no reset so contents
// survive a subsystem reset.
module dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory subsystem behind the single-cycle core: address decode, word RAM,
// GPIO/timer MMIO block and a sticky access-fault flag. Reads are combinational.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          ADDR_W       = 10,
    parameter logic [15:0] RAM_BASE_HI  = RAM_BASE_HI_DEF,
    parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] gpio_out,
    output logic        irq,
    output logic        fault
);

    logic [31:0] r_gpio;
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_match;
    logic        r_fault;

    logic        w_ram_sel;
    logic        w_mmio_sel;
    logic        w_aligned;
    logic        w_valid;
    logic        w_rd_en;
    logic        w_wr_en;
    logic        w_mmio_wr;
    logic [3:0]  w_off;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_mmio_rdata;
    logic [31:0] w_status;
    logic        w_fault_set;
    logic        w_match_set;
    logic        w_stat_wr;

    // Bits between the RAM word index and the base must be zero so the
    // window does not alias beyond the physical depth.
    assign w_ram_sel  = (addr[31:16] == RAM_BASE_HI) &&
                        ((addr[15:0] >> (ADDR_W + 2)) == 16'h0);
    assign w_mmio_sel = (addr[31:16] == MMIO_BASE_HI) && (addr[15:4] == 12'h0);
    assign w_aligned  = (addr[1:0] == 2'b00);
    assign w_valid    = cs && w_aligned && (w_ram_sel || w_mmio_sel);

    assign w_rd_en    = cs && rd && w_valid;
    assign w_wr_en    = cs && wr && w_valid;
    assign w_mmio_wr  = w_wr_en && w_mmio_sel;
    assign w_off      = addr[3:0];
    assign w_stat_wr  = w_mmio_wr && (w_off == OFF_STAT);

    assign w_fault_set = cs && (rd || wr) && !w_valid;
    assign w_match_set = (r_count == r_cmp);

    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (w_wr_en && w_ram_sel),
        .waddr (addr[ADDR_W+1:2]),
        .raddr (addr[ADDR_W+1:2]),
        .wdata (wdata),
        .rdata (w_ram_rdata)
    );

    always_comb begin
        w_status           = 32'h0;
        w_status[ST_MATCH] = r_match;
        w_status[ST_FAULT] = r_fault;
    end

    always_comb begin
        w_mmio_rdata = 32'h0;
        case (w_off)
            OFF_GPIO: w_mmio_rdata = r_gpio;
            OFF_CNT:  w_mmio_rdata = r_count;
            OFF_CMP:  w_mmio_rdata = r_cmp;
            OFF_STAT: w_mmio_rdata = w_status;
            default:  w_mmio_rdata = 32'h0;
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        if (w_rd_en) begin
            rdata = w_ram_sel ? w_ram_rdata : w_mmio_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpio  <= 32'h0;
            r_count <= 32'h0;
            r_cmp   <= 32'hFFFF_FFFF;
            r_match <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (w_mmio_wr && (w_off == OFF_GPIO)) begin
                r_gpio <= wdata;
            end
            if (w_mmio_wr && (w_off == OFF_CMP)) begin
                r_cmp <= wdata;
            end
            // A software load replaces the increment for that cycle.
            if (w_mmio_wr && (w_off == OFF_CNT)) begin
                r_count <= wdata;
            end else begin
                r_count <= r_count + 32'd1;
            end
            // Set takes priority over a same-cycle W1C.
            if (w_match_set) begin
                r_match <= 1'b1;
            end else if (w_stat_wr && wdata[ST_MATCH]) begin
                r_match <= 1'b0;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end else if (w_stat_wr && wdata[ST_FAULT]) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign gpio_out = r_gpio;
    assign irq      = r_match;
    assign fault    = r_fault;

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-memory subsystem directly downstream of the single-cycle CPU core.
- Consumes the core's data-memory interface: byte address, write data, chip select, read and write strobes. Returns read data in the same cycle.
- Contains a word RAM, a small memory-mapped I/O block (GPIO output register and a 32-bit free-running timer with compare and interrupt), and a sticky access-fault detector.

Parameters:
- ADDR_W, 10, RAM word-address width; RAM depth = 2**ADDR_W words.
- RAM_BASE_HI, 16'h1001, value of addr[31:16] that selects the RAM window.
- MMIO_BASE_HI, 16'hFFFF, value of addr[31:16] that selects the MMIO window.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  data-memory chip select from the core.
- rd  in  1  read strobe; qualified by cs.
- wr  in  1  write strobe; qualified by cs.
- addr  in  32  byte address (the core's ALU result).
- wdata  in  32  store data.
- rdata  out  32  load data, combinational.
- gpio_out  out  32  GPIO output register.
- irq  out  1  timer match flag; level output.
- fault  out  1  sticky access-fault flag.

Behaviour:
- Reset (asynchronous, active-high) clears gpio_out, timer count, timer compare, the match flag and the fault flag. Compare resets to 32'hFFFF_FFFF.
- RAM contents are not affected by reset.
- Access validity:
  - An access is valid when cs=1, addr[1:0]==0, and the address is mapped.
  - RAM is mapped when addr[31:16]==RAM_BASE_HI and addr[15:ADDR_W+2]==0.
  - MMIO is mapped when addr[31:16]==MMIO_BASE_HI and addr[15:4]==0.
- Reads are combinational with zero latency:
  - rdata = selected word when cs & rd & valid; otherwise 32'h0.
- Writes commit on the rising edge when cs & wr & valid. Invalid writes are dropped with no side effects.
- When rd and wr are asserted together, rdata shows the pre-write value; the write lands at the edge.
- MMIO register map (offset from MMIO base):
  - 0x0 GPIO_OUT: read/write.
  - 0x4 TIMER_COUNT: read/write; a write loads the count.
  - 0x8 TIMER_CMP: read/write.
  - 0xC STATUS: bit0 = match, bit1 = fault, other bits read 0. Writing 1 to a bit clears it (W1C).
- Timer:
  - Every edge, count <= count+1, wrapping from 32'hFFFF_FFFF to 0.
  - A write to TIMER_COUNT overrides the increment in that cycle: count <= wdata.
  - The match flag sets on the edge where the current count == compare, before increment.
  - irq = match flag.
- Fault:
  - Sets on the edge of any cycle where cs=1 and (rd|wr)=1 and the access is invalid (misaligned or unmapped).
  - cs=1 with rd=wr=0 never faults.
- Simultaneous set and clear: if a STATUS W1C and a set condition occur in the same cycle, set wins.
- Reset asserted mid-cycle overrides everything immediately, including a pending write to the MMIO registers.
- No state machine. All state is in the registers above plus the RAM array.

Decomposition:
- Shared package holds:
  - MMIO offset constants: OFF_GPIO=4'h0, OFF_CNT=4'h4, OFF_CMP=4'h8, OFF_STAT=4'hC.
  - Default base constants.
  - STATUS bit indices: ST_MATCH=0, ST_FAULT=1.
- One sub-module, dmem_ram: synchronous-write, asynchronous-read word array.
  - Ports: clk, we, waddr/raddr[ADDR_W-1:0], wdata, rdata.
  - No reset.
- Address decode, MMIO registers, timer and fault logic live in the top.

Test Plan:
- Reset, then read each MMIO register -> GPIO=0, CNT=0 (sampled immediately after reset release), CMP=32'hFFFF_FFFF, STATUS=0; irq=0, fault=0.
- Write 32'hDEADBEEF to 0x1001_0004, then read 0x1001_0004 -> rdata=32'hDEADBEEF. Read 0x1001_0000 -> unchanged. Same-cycle rd+wr of 32'h1 to 0x1001_0004 -> rdata=32'hDEADBEEF that cycle, 32'h1 the next.
- Write CNT=32'hFFFF_FFFE, CMP=32'h0 -> count wraps to 0 after 2 edges. irq rises on the edge after count==0 is observed. Write 32'h1 to 0xFFFF_000C -> irq=0 unless a match occurs in the same cycle.
- Read 0x1001_0002 (misaligned) -> rdata=0, fault=1 next cycle. Write to 0x2000_0000 -> RAM and MMIO unchanged, fault stays 1. Write 32'h2 to STATUS -> fault=0.
- Write CNT=5 in the same cycle as count would increment -> next read of CNT = 6 one cycle later (load of 5, then +1). Write STATUS W1C in the same cycle as a count==cmp match -> match stays 1.
- Assert reset mid-test after writing GPIO=32'hA5A5A5A5 -> gpio_out=0 asynchronously. Previously written RAM word still reads back its value.
